// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell driven one bit per cycle by serial_adder.
module fa (
    input  logic Cin,
    input  logic A,
    input  logic B,
    output logic Cout,
    output logic Sum
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one fa cell, carry fed back.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CW-1:0]    count_reg;
    logic             fa_cout;
    logic             fa_sum;

    fa u_fa (
        .Cin  (carry_reg),
        .A    (a_sr_reg[0]),
        .B    (b_sr_reg[0]),
        .Cout (fa_cout),
        .Sum  (fa_sum)
    );

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            count_reg <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        carry_reg <= cin;
                        count_reg <= '0;
                        sum_reg   <= '0;
                        state_reg <= ST_RUN;
                    end else if (state_reg == ST_DONE) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
                    carry_reg <= fa_cout;
                    a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_BIT) begin
                        cout_reg  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_reg here is the carry into the MSB position
                        ovf_reg   <= fa_cout ^ carry_reg;
`endif
                        state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_reg;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; signed overflow from range of signed sum
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint sx, sy, s;
        sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
        sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
        s  = sx + sy + longint'(c);
        return (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
    endfunction

    // Called at a negedge; start is seen by the next rising edge (edge 0).
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done from the cycle after edge 0; optionally pokes start at cycle poke_cyc.
    task automatic finish(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input int poke_cyc);
        int cyc;
        int busy_cnt;
        logic [W:0] exp;
        cyc = 0;
        busy_cnt = 0;
        exp = ref_add(x, y, c);
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (cyc == poke_cyc) begin
                start = 1'b1;
                a = 8'hAA;
                b = W'($urandom);
                cin = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'(W));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, ".sum"}, 64'(sum), 64'(exp[W-1:0]));
        check({tag, ".cout"}, 64'(cout), 64'(exp[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, 64'(ovf), 64'(ref_ovf(x, y, c)));
`endif
        $display("[TB] %s a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d", tag, x, y, c, sum, cout);
    endtask

    task automatic idle_after(input string tag, input logic [W:0] exp);
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".held_sum"}, 64'({cout, sum}), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         c;
        int           dones;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outs", 64'({busy, done, cout, sum}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(8'h35, 8'h4A, 1'b0);
        finish("plan1", 8'h35, 8'h4A, 1'b0, -1);
        idle_after("plan1", ref_add(8'h35, 8'h4A, 1'b0));

        launch(8'hFF, 8'h01, 1'b0);
        finish("plan2a", 8'hFF, 8'h01, 1'b0, -1);
        idle_after("plan2a", ref_add(8'hFF, 8'h01, 1'b0));
        launch(8'hFF, 8'hFF, 1'b1);
        finish("plan2b", 8'hFF, 8'hFF, 1'b1, -1);
        idle_after("plan2b", ref_add(8'hFF, 8'hFF, 1'b1));

        // Start during RUN must be ignored.
        launch(8'h10, 8'h20, 1'b0);
        finish("ignore", 8'h10, 8'h20, 1'b0, 3);
        idle_after("ignore", ref_add(8'h10, 8'h20, 1'b0));

        // Back-to-back: start asserted in the done cycle.
        launch(8'h5C, 8'h21, 1'b1);
        finish("b2b_first", 8'h5C, 8'h21, 1'b1, -1);
        launch(8'h01, 8'h02, 1'b0);
        check("b2b.busy_next", 64'(busy), 64'd1);
        finish("b2b_second", 8'h01, 8'h02, 1'b0, -1);
        idle_after("b2b_second", ref_add(8'h01, 8'h02, 1'b0));

`ifdef SERIAL_ADDER_OVF_EN
        launch(8'h7F, 8'h01, 1'b0);
        finish("ovf_pos", 8'h7F, 8'h01, 1'b0, -1);
        launch(8'hFF, 8'h01, 1'b0);
        finish("ovf_none", 8'hFF, 8'h01, 1'b0, -1);
        @(negedge clk);
`endif

        // Reset mid-RUN aborts immediately with no following done pulse.
        launch(8'hC3, 8'h77, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midrst.outs", 64'({busy, done, cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrst.no_done", 64'(dones), 64'd0);

        // Randomized operations, with random back-to-back chaining and operand churn.
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            if ((i % 5) == 0) x = 8'hFF;
            if ((i % 7) == 0) y = 8'h80;
            launch(x, y, c);
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            finish($sformatf("rand%0d", i), x, y, c, -1);
            if ($urandom_range(0, 1) == 1) idle_after($sformatf("rand%0d", i), ref_add(x, y, c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around the single-bit full-adder cell `fa`.
- Operands are loaded in parallel on a start request and fed to one `fa` instance LSB first.
- Cout is registered and fed back as the next bit's Cin.
- The sum is reassembled in a shift register and presented with a one-cycle done pulse.
- It is the sequential stage that drives the full-adder cell and consumes its Cout/Sum outputs.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to begin an addition; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result; held from done until the next accepted start.
- cout  output  1  final carry-out; held like sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and bit counter all cleared.
- FSM states: IDLE, RUN, DONE. No other states are reachable; any illegal encoding returns to IDLE.
- IDLE or DONE, start=1 at an edge (start accepted):
  - load a, b into shift regs; carry<=cin; count<=0; sum<=0; state<=RUN.
- IDLE, start=0: hold. DONE, start=0: go to IDLE next edge.
- RUN, each edge:
  - fa inputs = (carry, a_sr[0], b_sr[0]).
  - sum <= {Sum, sum[WIDTH-1:1]} (shift in from MSB); carry <= Cout.
  - a_sr, b_sr shift right by one; count <= count+1.
  - When count==WIDTH-1: cout <= Cout; state <= DONE.
- Latency: start accepted at edge 0; bits processed on edges 1..WIDTH; done=1 in the cycle after edge WIDTH. Total WIDTH+1 edges from start acceptance to done.
- busy = (state==RUN); done = (state==DONE). Both are registered state decodes with no combinational path from start.
- start while busy: ignored. Operands and carry are not disturbed and no error is flagged.
- start in DONE (back-to-back): accepted. done is high in that cycle; the new operation begins and busy rises next cycle.
- a/b/cin changes after acceptance: no effect on the operation in flight.
- Counter width is $clog2(WIDTH)+1 bits. It must never wrap during RUN.
- Reset mid-RUN: immediate abort to the reset values; no done pulse is produced.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output `ovf` (1 bit, reset 0).
  - The carry into the MSB bit (carry flop value when count==WIDTH-1) is XORed with the final Cout.
  - Registered alongside cout; valid and held under the same rules as cout.
  - Indicates two's-complement signed overflow.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
- One sub-module: the existing full-adder cell `fa`, instantiated once with port order (Cin, A, B, Cout, Sum).
- All sequencing (shift registers, carry flop, counter, FSM) stays in serial_adder.

Test Plan:
- a=8'h35, b=8'h4A, cin=0, start pulse -> busy for 8 cycles, done at edge 9 with sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start a=8'h10, b=8'h20; pulse start again at RUN cycle 3 with a=8'hAA -> ignored; result is sum=8'h30, cout=0.
- Assert start exactly on the done cycle with a=8'h01, b=8'h02 -> second result sum=8'h03 after a further 9 edges, with no idle gap.
- Drop rst_n low mid-RUN (count=4) -> busy, done, sum and cout read 0 immediately; no done pulse follows.
- With SERIAL_ADDER_OVF_EN:
  - a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
  - a=8'hFF, b=8'h01 -> ovf=0.
